// File: rtl/ika2151_dac_pkg.sv
// Shared frame geometry and sample type for the YM3012-style DAC receiver.
package ika2151_dac_pkg;

  localparam int FRAME_BITS = 16;
  localparam int MANT_LSB   = 3;
  localparam int MANT_W     = 10;
  localparam int EXP_LSB    = 13;
  localparam int EXP_W      = 3;
  localparam int SAMPLE_W   = 16;
  localparam int CNT_W      = 5;

  // Only exponent and mantissa are retained; the dummy LSBs shift straight through.
  localparam int SR_W       = FRAME_BITS - MANT_LSB;
  localparam int SR_EXP_LSB = EXP_LSB - MANT_LSB;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  function automatic sample_t mant_to_signed(input logic [MANT_W-1:0] m);
    logic [MANT_W-1:0] s;
    s = {~m[MANT_W-1], m[MANT_W-2:0]};
    return {{(SAMPLE_W-MANT_W){s[MANT_W-1]}}, s};
  endfunction

endpackage

// File: rtl/ika2151_fp_decode.sv
// Combinational 3-bit exponent / 10-bit offset-binary mantissa to signed 16-bit PCM.
// No saturation: worst case 512 << 6 lands exactly on -32768.
import ika2151_dac_pkg::*;

module ika2151_fp_decode #(
  parameter bit EXP0_AS_ZERO = 1'b1
) (
  input  logic [MANT_W-1:0]   i_mant,
  input  logic [EXP_W-1:0]    i_exp,
  output logic [SAMPLE_W-1:0] o_sample
);

  sample_t          w_ext;
  logic [EXP_W-1:0] w_shamt;

  assign w_ext   = mant_to_signed(i_mant);
  assign w_shamt = (i_exp == '0) ? '0 : i_exp - 3'd1;

  always_comb begin
    o_sample = '0;
    if (!(EXP0_AS_ZERO && (i_exp == '0))) begin
      o_sample = w_ext <<< w_shamt;
    end
  end

endmodule

// File: rtl/ika2151_dac_rx.sv
// Deserialises SO under SH1/SH2 windows and decodes each frame into o_L/o_R.
// Output and VALID update on the phi1 enable that sees the window fall; pulses last one EMUCLK.
import ika2151_dac_pkg::*;

module ika2151_dac_rx #(
  parameter bit EXP0_AS_ZERO    = 1'b1,
  parameter bit CHECK_FRAME_LEN = 1'b1
) (
  input  logic        i_EMUCLK,
  input  logic        i_MRST,
  input  logic        i_phi1_PCEN_n,
  input  logic        i_SO,
  input  logic        i_SH1,
  input  logic        i_SH2,
  output logic [15:0] o_L,
  output logic [15:0] o_R,
  output logic        o_L_VALID,
  output logic        o_R_VALID,
  output logic        o_FMT_ERR
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_BITS);

  logic [SR_W-1:0]     r_sr;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_sh1_d;
  logic                r_sh2_d;
  logic [SAMPLE_W-1:0] r_l;
  logic [SAMPLE_W-1:0] r_r;
  logic                r_l_vld;
  logic                r_r_vld;
  logic                r_err;

  logic                w_en;
  logic                w_win;
  logic                w_fall1;
  logic                w_fall2;
  logic                w_len_ok;
  logic [SAMPLE_W-1:0] w_dec;

  assign w_en     = ~i_phi1_PCEN_n;
  assign w_win    = i_SH1 | i_SH2;
  assign w_fall1  = r_sh1_d & ~i_SH1;
  assign w_fall2  = r_sh2_d & ~i_SH2;
  assign w_len_ok = !CHECK_FRAME_LEN || (r_cnt == CNT_FRAME);

  // One decoder serves both channels: a legal frame only ever ends one window at a time.
  ika2151_fp_decode #(
    .EXP0_AS_ZERO(EXP0_AS_ZERO)
  ) u_decode (
    .i_mant  (r_sr[MANT_W-1:0]),
    .i_exp   (r_sr[SR_EXP_LSB +: EXP_W]),
    .o_sample(w_dec)
  );

  always_ff @(posedge i_EMUCLK) begin
    if (i_MRST) begin
      r_sr    <= '0;
      r_cnt   <= '0;
      r_sh1_d <= 1'b0;
      r_sh2_d <= 1'b0;
      r_l     <= '0;
      r_r     <= '0;
      r_l_vld <= 1'b0;
      r_r_vld <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_l_vld <= 1'b0;
      r_r_vld <= 1'b0;
      r_err   <= 1'b0;
      if (w_en) begin
        r_sh1_d <= i_SH1;
        r_sh2_d <= i_SH2;
        if (w_win) begin
          r_sr <= {i_SO, r_sr[SR_W-1:1]};
          if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        // A bit shifted on the closing enable already belongs to the next window.
        if (w_fall1 | w_fall2) begin
          r_cnt <= {{(CNT_W-1){1'b0}}, w_win};
        end
        if (w_fall1 ^ w_fall2) begin
          if (!w_len_ok) begin
            r_err <= 1'b1;
          end else if (w_fall1) begin
            r_l     <= w_dec;
            r_l_vld <= 1'b1;
          end else begin
            r_r     <= w_dec;
            r_r_vld <= 1'b1;
          end
        end
        if ((w_fall1 & w_fall2) | (i_SH1 & i_SH2)) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign o_L       = r_l;
  assign o_R       = r_r;
  assign o_L_VALID = r_l_vld;
  assign o_R_VALID = r_r_vld;
  assign o_FMT_ERR = r_err;

endmodule

// File: tb/tb_ika2151_dac_rx.sv
// Directed bench for ika2151_dac_rx with an event scoreboard on the output pulses.
module tb_ika2151_dac_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        mrst, pcen_n, so, sh1, sh2;
  logic [15:0] o_l, o_r;
  logic        l_vld, r_vld, fmt_err;
  logic [15:0] e0_l, e0_r;
  logic        e0_lv, e0_rv, e0_err;

  typedef struct {
    int          kind;
    logic [15:0] val;
  } ev_t;

  ev_t         sb[$];
  int          checks = 0;
  int          errors = 0;
  int          n_main = 0;
  int          n_e0   = 0;
  logic [15:0] exp_l  = '0;
  logic [15:0] exp_r  = '0;

  ika2151_dac_rx #(.EXP0_AS_ZERO(1'b1), .CHECK_FRAME_LEN(1'b1)) dut (
    .i_EMUCLK(clk), .i_MRST(mrst), .i_phi1_PCEN_n(pcen_n),
    .i_SO(so), .i_SH1(sh1), .i_SH2(sh2),
    .o_L(o_l), .o_R(o_r), .o_L_VALID(l_vld), .o_R_VALID(r_vld), .o_FMT_ERR(fmt_err)
  );

  ika2151_dac_rx #(.EXP0_AS_ZERO(1'b0), .CHECK_FRAME_LEN(1'b1)) dut_e0 (
    .i_EMUCLK(clk), .i_MRST(mrst), .i_phi1_PCEN_n(pcen_n),
    .i_SO(so), .i_SH1(sh1), .i_SH2(sh2),
    .o_L(e0_l), .o_R(e0_r), .o_L_VALID(e0_lv), .o_R_VALID(e0_rv), .o_FMT_ERR(e0_err)
  );

  // Reference decode written arithmetically: offset mantissa times a power of two.
  function automatic logic [15:0] model(input logic [9:0] m, input logic [2:0] e, input bit zero0);
    int s;
    s = int'(m) - 512;
    if (e == 3'd0) return zero0 ? 16'h0000 : 16'(s);
    return 16'(s * (1 << (int'(e) - 1)));
  endfunction

  function automatic logic [15:0] mk(input logic [9:0] m, input logic [2:0] e, input logic [2:0] d);
    return {e, m, d};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic pop_check(input int kind, input logic [15:0] val);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_unexpected kind %0d observed %h expected no event", kind, val);
    end else begin
      e = sb.pop_front();
      assert (kind === e.kind && val === e.val) else begin
        errors++;
        $error("FAIL sb_event observed kind %0d val %h expected kind %0d val %h", kind, val, e.kind, e.val);
      end
    end
  endtask

  task automatic push(input int kind, input logic [15:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (l_vld === 1'b1)   pop_check(0, o_l);
    if (r_vld === 1'b1)   pop_check(1, o_r);
    if (fmt_err === 1'b1) pop_check(2, 16'h0000);
    n_main += int'(l_vld === 1'b1) + int'(r_vld === 1'b1) + int'(fmt_err === 1'b1);
    n_e0   += int'(e0_lv === 1'b1) + int'(e0_rv === 1'b1) + int'(e0_err === 1'b1);
  end

  task automatic step(input logic en, input logic d, input logic w1, input logic w2);
    pcen_n = ~en;
    so     = d;
    sh1    = w1;
    sh2    = w2;
    @(posedge clk);
    #1;
  endtask

  // Idle cycles carry random pins: the receiver must ignore them while PCEN_n is high.
  task automatic gap(input int n);
    for (int g = 0; g < n; g++)
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic send_frame(input bit right, input logic [15:0] w, input int nbits, input bit gaps);
    for (int i = 0; i < nbits; i++) begin
      step(1'b1, w[i % 16], !right, right);
      if (gaps) gap(int'($urandom_range(0, 3)));
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic left_frame(input logic [9:0] m, input logic [2:0] e, input logic [2:0] d, input bit gaps);
    exp_l = model(m, e, 1'b1);
    push(0, exp_l);
    send_frame(1'b0, mk(m, e, d), 16, gaps);
    chk("left_value", o_l, exp_l);
  endtask

  task automatic right_frame(input logic [9:0] m, input logic [2:0] e);
    exp_r = model(m, e, 1'b1);
    push(1, exp_r);
    send_frame(1'b1, mk(m, e, 3'b000), 16, 1'b0);
    chk("right_value", o_r, exp_r);
  endtask

  initial begin
    mrst = 1'b1; pcen_n = 1'b0; so = 1'b0; sh1 = 1'b0; sh2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    mrst = 1'b0;
    chk("reset_L", o_l, 16'h0000);
    chk("reset_R", o_r, 16'h0000);
    chk("reset_pulses", {13'b0, l_vld, r_vld, fmt_err}, 16'h0000);

    left_frame(10'h3FF, 3'd7, 3'b000, 1'b0);
    chk("left_const_7FC0", o_l, 16'h7FC0);
    chk("R_untouched", o_r, 16'h0000);

    right_frame(10'h000, 3'd7);
    chk("right_const_8000", o_r, 16'h8000);
    right_frame(10'h201, 3'd1);
    chk("right_const_0001", o_r, 16'h0001);
    right_frame(10'h200, 3'd4);
    chk("L_after_right", o_l, 16'h7FC0);

    left_frame(10'h3FF, 3'd0, 3'b111, 1'b0);
    chk("exp0_zero", o_l, 16'h0000);
    chk("exp0_as_one", e0_l, 16'h01FF);

    left_frame(10'h155, 3'd3, 3'b010, 1'b0);
    push(2, 16'h0000);
    send_frame(1'b0, mk(10'h2AA, 3'd5, 3'b000), 15, 1'b0);
    chk("short_hold_L", o_l, exp_l);
    push(2, 16'h0000);
    send_frame(1'b0, mk(10'h2AA, 3'd5, 3'b000), 17, 1'b0);
    chk("long_hold_L", o_l, exp_l);

    for (int i = 0; i < 17; i++) push(2, 16'h0000);
    for (int i = 0; i < 16; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("overlap_hold_L", o_l, exp_l);
    chk("overlap_hold_R", o_r, exp_r);
    left_frame(10'h0AA, 3'd5, 3'b001, 1'b0);

    left_frame(10'h3FF, 3'd7, 3'b110, 1'b1);
    left_frame(10'h07F, 3'd6, 3'b000, 1'b1);

    // 48 enables: a wrapping counter would read 16 here and wrongly accept the frame.
    push(2, 16'h0000);
    for (int i = 0; i < 48; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("saturate_hold_L", o_l, exp_l);

    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    mrst = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    mrst = 1'b0;
    exp_l = 16'h0000;
    exp_r = 16'h0000;
    chk("midreset_L", o_l, 16'h0000);
    chk("midreset_R", o_r, 16'h0000);
    push(2, 16'h0000);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("midreset_frame_L", o_l, 16'h0000);

    left_frame(10'h123, 3'd2, 3'b000, 1'b0);

    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("sb_drained", 16'(sb.size()), 16'h0000);
    chk("e0_pulse_count", 16'(n_e0), 16'(n_main));
    chk("e0_R_match", e0_r, o_r);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ika2151_dac_rx.md
Name: ika2151_dac_rx

Overview:
- Downstream consumer of the OPM core's serial DAC output (SO, SH1, SH2). Behaves as the YM3012-style receiver.
- Deserialises each 16-bit channel frame and decodes the 3-bit-exponent / 10-bit-mantissa floating-point word into signed 16-bit linear PCM.
- Presents left and right samples with per-channel valid strobes for mixers or audio back-ends in the emulator top level.
- Runs entirely on the emulator master clock, gated by the phi1 positive clock enable.

Parameters:
- EXP0_AS_ZERO, 1: 1 = exponent 0 decodes to 0; 0 = exponent 0 is treated as exponent 1.
- CHECK_FRAME_LEN, 1: 1 = frames whose bit count is not 16 are discarded and flagged; 0 = the frame is decoded regardless of count.

Ports:
- i_EMUCLK  in  1  emulator master clock
- i_MRST  in  1  synchronous, active-high reset
- i_phi1_PCEN_n  in  1  phi1 positive clock enable, active low; all SO/SH sampling happens only on these cycles
- i_SO  in  1  serial data, LSB first
- i_SH1  in  1  left-channel frame window, high while the left frame shifts
- i_SH2  in  1  right-channel frame window, high while the right frame shifts
- o_L  out  16  signed left sample
- o_R  out  16  signed right sample
- o_L_VALID  out  1  one-EMUCLK pulse when o_L updates
- o_R_VALID  out  1  one-EMUCLK pulse when o_R updates
- o_FMT_ERR  out  1  one-EMUCLK pulse on a malformed or overlapping frame

Behaviour:
- Interface (already decided): one clock, i_EMUCLK; reset i_MRST is synchronous and active-high.
- Reset: o_L = 0, o_R = 0, all pulses = 0, shift register = 0, bit counter = 0, sh1_d = 0, sh2_d = 0.
- Enable cycle: an EMUCLK edge where i_phi1_PCEN_n = 0. No state changes on any other cycle, except that pulse outputs clear on the following EMUCLK.
- Shifting, on an enable cycle with (i_SH1 | i_SH2) = 1:
  - sr <= {i_SO, sr[15:1]} (shift right, new bit enters bit 15).
  - cnt <= cnt + 1, saturating at 31 (5-bit counter).
- Frame layout after 16 shifts:
  - sr[2:0] dummy bits.
  - sr[12:3] mantissa m.
  - sr[15:13] exponent e.
- Falling-edge detect, on an enable cycle:
  - fall1 = sh1_d & ~i_SH1; fall2 = sh2_d & ~i_SH2.
  - sh1_d and sh2_d are then updated from the inputs.
- On fall1 XOR fall2:
  - If CHECK_FRAME_LEN = 1 and cnt != 16: pulse o_FMT_ERR, leave the output unchanged.
  - Otherwise: decode, write o_L (on fall1) or o_R (on fall2), and pulse the matching VALID.
  - cnt <= 0 in both cases.
- Latency: the output register and VALID change on the EMUCLK edge of the enable cycle that detects the fall. VALID is high for exactly that one EMUCLK.
- Simultaneous fall1 & fall2: pulse o_FMT_ERR, no output update, cnt <= 0.
- Overlap: i_SH1 & i_SH2 both high on an enable cycle pulses o_FMT_ERR. Shifting still occurs and the frame is still judged at its fall.
- Decode (combinational):
  - s = {~m[9], m[8:0]} as 10-bit two's complement (mantissa is offset binary).
  - result = sign-extend s to 16 bits, then arithmetic-left-shift by (e - 1) for e = 1..7.
  - e = 0: result = 0 if EXP0_AS_ZERO = 1, else shift by 0.
  - No saturation is needed: maximum magnitude is 512 << 6 = 32768, which fits as -32768.
- Reset mid-frame: all state clears.
  - A window still high after reset accumulates fewer than 16 bits.
  - With CHECK_FRAME_LEN = 1 its fall flags an error; it is never decoded as valid.
- Counter saturation: a window longer than 31 enables holds cnt at 31 and is always flagged when checked.

Decomposition:
- Package ika2151_dac_pkg:
  - FRAME_BITS = 16, MANT_LSB = 3, MANT_W = 10, EXP_LSB = 13, EXP_W = 3, SAMPLE_W = 16.
  - A function/typedef for the signed sample.
- Sub-module ika2151_fp_decode: combinational (m, e) -> signed 16-bit, parameterised by EXP0_AS_ZERO. Instantiated once and shared by both channels, since falls are mutually exclusive in valid operation.
- The top holds the shift register, counter, edge detect and output registers.

Test Plan:
- Left frame, m = 10'h3FF, e = 7, dummy bits 0, 16 enables under SH1, then SH1 low -> o_L = 16'h7FC0, one o_L_VALID pulse, o_R unchanged at 0.
- Right frame, m = 10'h000, e = 7 -> o_R = 16'h8000. Then m = 10'h201, e = 1 -> o_R = 16'h0001. Then m = 10'h200, e = 4 -> o_R = 0.
- Exponent 0, m = 10'h3FF: EXP0_AS_ZERO = 1 -> o_L = 0; EXP0_AS_ZERO = 0 -> o_L = 16'h01FF.
- SH1 held for 15 enables, then 17 enables (CHECK_FRAME_LEN = 1) -> an o_FMT_ERR pulse each time, no o_L_VALID, o_L holds its previous value.
- SH1 and SH2 both high for 16 enables, falling together -> o_FMT_ERR pulses, neither VALID asserts, next clean left frame decodes correctly.
- i_MRST asserted after 8 SH1 bits, released, SH1 continues 8 more bits then falls -> o_FMT_ERR, o_L = 0. Enable cycles with PCEN_n = 1 cause no shifts (frame with gaps decodes identically).
